// File: rtl/l1_pkg.sv
// Shared widths, status encoding and agent state type
// for the L1 bus-side agent.
package l1_pkg;

    localparam int LINES  = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int STAT_W = 2;
    localparam int IDX_W  = $clog2(LINES);

    localparam logic [STAT_W-1:0] ST_M = 2'b00;
    localparam logic [STAT_W-1:0] ST_E = 2'b01;
    localparam logic [STAT_W-1:0] ST_S = 2'b10;
    localparam logic [STAT_W-1:0] ST_I = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SNP_SCAN,
        SNP_RESP,
        FL_SCAN,
        FL_WB,
        FL_DONE
    } agentState_t;

endpackage

// File: rtl/l1_line_match.sv
// Address/status compare for one L1 line; invalid lines never match,
// so an undriven address on an invalid line cannot produce a hit.
module l1_line_match
    import l1_pkg::*;
(
    input  logic [STAT_W-1:0] status,
    input  logic [ADDR_W-1:0] lineAddr,
    input  logic [ADDR_W-1:0] key,
    output logic              match
);

    assign match = (status != ST_I) && (lineAddr == key);

endmodule

// File: rtl/l1_bus_agent.sv
// Bus-side agent for the L1: snoop lookups by address and
// flush of Modified lines over a valid/ready writeback port.
module l1_bus_agent
    import l1_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              snoop_req,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              snoop_ack,
    output logic              snoop_hit,
    output logic [DATA_W-1:0] snoop_data,
    output logic [STAT_W-1:0] snoop_status,
    input  logic              flush_req,
    output logic              flush_busy,
    output logic              flush_done,
    output logic [IDX_W-1:0]  l1_local_addr,
    input  logic [DATA_W-1:0] l1_data,
    input  logic [ADDR_W-1:0] l1_addr,
    input  logic [STAT_W-1:0] l1_status,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data
);

    agentState_t       state, stateNext;
    logic [IDX_W-1:0]  idx, idxNext;
    logic [ADDR_W-1:0] snoopKey, snoopKeyNext;
    logic              hitQ, hitNext;
    logic [DATA_W-1:0] dataQ, dataNext;
    logic [STAT_W-1:0] statQ, statNext;
    logic [ADDR_W-1:0] wrAddrQ, wrAddrNext;
    logic [DATA_W-1:0] wrDataQ, wrDataNext;
    logic              lineHit;
    logic              lastLine;

    l1_line_match uMatch (
        .status   (l1_status),
        .lineAddr (l1_addr),
        .key      (snoopKey),
        .match    (lineHit)
    );

    assign lastLine = (idx == IDX_W'(LINES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            snoopKey <= '0;
            hitQ     <= 1'b0;
            dataQ    <= '0;
            statQ    <= ST_I;
            wrAddrQ  <= '0;
            wrDataQ  <= '0;
        end else begin
            state    <= stateNext;
            idx      <= idxNext;
            snoopKey <= snoopKeyNext;
            hitQ     <= hitNext;
            dataQ    <= dataNext;
            statQ    <= statNext;
            wrAddrQ  <= wrAddrNext;
            wrDataQ  <= wrDataNext;
        end
    end

    always_comb begin
        stateNext    = state;
        idxNext      = idx;
        snoopKeyNext = snoopKey;
        hitNext      = hitQ;
        dataNext     = dataQ;
        statNext     = statQ;
        wrAddrNext   = wrAddrQ;
        wrDataNext   = wrDataQ;
        unique case (state)
            IDLE: begin
                if (snoop_req) begin
                    snoopKeyNext = snoop_addr;
                    idxNext      = '0;
                    stateNext    = SNP_SCAN;
                end else if (flush_req) begin
                    idxNext   = '0;
                    stateNext = FL_SCAN;
                end
            end
            SNP_SCAN: begin
                // Scanning upward makes the lowest matching line win.
                if (lineHit) begin
                    hitNext   = 1'b1;
                    dataNext  = l1_data;
                    statNext  = l1_status;
                    stateNext = SNP_RESP;
                end else if (lastLine) begin
                    hitNext   = 1'b0;
                    dataNext  = '0;
                    statNext  = ST_I;
                    stateNext = SNP_RESP;
                end else begin
                    idxNext = idx + IDX_W'(1);
                end
            end
            SNP_RESP: stateNext = IDLE;
            FL_SCAN: begin
                if (l1_status == ST_M) begin
                    wrAddrNext = l1_addr;
                    wrDataNext = l1_data;
                    stateNext  = FL_WB;
                end else if (lastLine) begin
                    stateNext = FL_DONE;
                end else begin
                    idxNext = idx + IDX_W'(1);
                end
            end
            FL_WB: begin
                if (mem_wr_ready) begin
                    if (lastLine) begin
                        stateNext = FL_DONE;
                    end else begin
                        idxNext   = idx + IDX_W'(1);
                        stateNext = FL_SCAN;
                    end
                end
            end
            FL_DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign l1_local_addr = idx;
    assign snoop_ack     = (state == SNP_RESP);
    assign snoop_hit     = hitQ;
    assign snoop_data    = dataQ;
    assign snoop_status  = statQ;
    assign flush_busy    = (state == FL_SCAN) || (state == FL_WB);
    assign flush_done    = (state == FL_DONE);
    assign mem_wr_valid  = (state == FL_WB);
    assign mem_wr_addr   = wrAddrQ;
    assign mem_wr_data   = wrDataQ;

endmodule
